// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: spawns, scrolls and retires cactus obstacle slots for the runner game.
// Optional: define OBSTACLE_DIFFICULTY_RAMP_EN to shorten the spawn gap as spawns accumulate.
module obstacle_scheduler #(
    parameter int NUM_SLOTS = 3,
    parameter int X_W       = 11,
    parameter int SPAWN_X   = 640,
    parameter int OBJ_WIDTH = 26,
    parameter int MIN_GAP   = 150,
    parameter int INIT_GAP  = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic                     halt,
    input  logic                     restart,
    input  logic [7:0]               random,
    output logic [NUM_SLOTS-1:0]     slot_valid,
    output logic [NUM_SLOTS*X_W-1:0] slot_x,
    output logic [NUM_SLOTS*2-1:0]   slot_type,
    output logic                     spawn_pulse,
    output logic                     running,
    output logic                     overflow
);
    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;
    localparam logic [8:0]     MIN_G  = 9'(MIN_GAP);
    localparam logic [8:0]     INIT_G = 9'(INIT_GAP);
    localparam logic [X_W-1:0] NEW_X  = X_W'(SPAWN_X + OBJ_WIDTH);
    state_t                          state_q, state_d;
    logic [NUM_SLOTS-1:0]            valid_q, valid_d;
    logic [NUM_SLOTS-1:0][X_W-1:0]   x_q, x_d;
    logic [NUM_SLOTS-1:0][1:0]       type_q, type_d;
    logic [8:0]                      gap_q, gap_d;
    logic                            pulse_q, pulse_d;
    logic                            ovf_q, ovf_d;
    logic [8:0]                      reload;
    logic [1:0]                      new_type;
    logic                            placed;
    assign new_type = (random[1:0] == 2'd3) ? 2'd0 : random[1:0];
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
    localparam logic [8:0] HALF_G = 9'(MIN_GAP / 2);
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] quarter, sub;
    assign quarter = {1'b0, cnt_q} >> 2;
    assign sub     = (quarter > HALF_G) ? HALF_G : quarter;
    assign reload  = MIN_G - sub + {3'b0, random[7:2]};
`else
    assign reload  = MIN_G + {3'b0, random[7:2]};
`endif
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        x_d     = x_q;
        type_d  = type_q;
        gap_d   = gap_q;
        pulse_d = 1'b0;
        ovf_d   = ovf_q;
        placed  = 1'b0;
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
        cnt_d   = cnt_q;
`endif
        if (restart) begin
            state_d = RUN;
            valid_d = '0;
            x_d     = '0;
            type_d  = '0;
            gap_d   = INIT_G;
            ovf_d   = 1'b0;
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
            cnt_d   = '0;
`endif
        end else if (state_q == RUN && halt) begin
            state_d = FROZEN;
        end else if (state_q == RUN && tick) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid_q[i]) begin
                    x_d[i] = x_q[i] - 1'b1;
                    if (x_q[i] == X_W'(1)) valid_d[i] = 1'b0;
                end
            end
            if (gap_q != '0) begin
                gap_d = gap_q - 9'd1;
            end else if (!(&valid_q)) begin
                // free-slot search uses pre-tick validity, so a slot retiring now is skipped
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!valid_q[i] && !placed) begin
                        placed     = 1'b1;
                        valid_d[i] = 1'b1;
                        x_d[i]     = NEW_X;
                        type_d[i]  = new_type;
                    end
                end
                gap_d   = reload;
                pulse_d = 1'b1;
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
                cnt_d   = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            x_q     <= '0;
            type_q  <= '0;
            gap_q   <= INIT_G;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            type_q  <= type_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif
    assign slot_valid  = valid_q;
    assign slot_x      = x_q;
    assign slot_type   = type_q;
    assign spawn_pulse = pulse_q;
    assign running     = (state_q == RUN);
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: vector table, hand sequences and random run against a slot-level model.
module tb_obstacle_scheduler;
    localparam int SPAWN = 666;
    logic        clk = 0, reset_n = 0, tick = 0, halt = 0, restart = 0;
    logic [7:0]  random = 0;
    logic [2:0]  slot_valid, v2;
    logic [32:0] slot_x, x2;
    logic [5:0]  slot_type, t2;
    logic        spawn_pulse, running, overflow, p2, r2, o2;
    int checks = 0, errors = 0;

    obstacle_scheduler dut (.clk(clk), .reset_n(reset_n), .tick(tick), .halt(halt),
        .restart(restart), .random(random), .slot_valid(slot_valid), .slot_x(slot_x),
        .slot_type(slot_type), .spawn_pulse(spawn_pulse), .running(running), .overflow(overflow));
    obstacle_scheduler #(.MIN_GAP(10)) dut2 (.clk(clk), .reset_n(reset_n), .tick(tick),
        .halt(halt), .restart(restart), .random(random), .slot_valid(v2), .slot_x(x2),
        .slot_type(t2), .spawn_pulse(p2), .running(r2), .overflow(o2));

    always #5 clk = ~clk;

    // behavioural model: mode 0 idle, 1 playing, 2 frozen
    int mv[3], mx[3], mt[3];
    int mgap, mmode, mpul, movf, mcnt;

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin mv[i] = 0; mx[i] = 0; mt[i] = 0; end
        mgap = 64; movf = 0; mcnt = 0; mpul = 0;
    endfunction

    function automatic void model_step(input bit t, h, r, input int rnd);
        int free_slot, sub;
        mpul = 0;
        if (r) begin
            model_clear();
            mmode = 1;
        end else if (mmode == 1 && h) begin
            mmode = 2;
        end else if (mmode == 1 && t) begin
            free_slot = -1;
            for (int i = 2; i >= 0; i--) if (mv[i] == 0) free_slot = i;
            for (int i = 0; i < 3; i++) if (mv[i] != 0) begin
                mx[i] = mx[i] - 1;
                if (mx[i] == 0) mv[i] = 0;
            end
            if (mgap > 0) mgap = mgap - 1;
            else if (free_slot >= 0) begin
                mv[free_slot] = 1;
                mx[free_slot] = SPAWN;
                mt[free_slot] = (rnd % 4 == 3) ? 0 : rnd % 4;
                sub = 0;
`ifdef OBSTACLE_DIFFICULTY_RAMP_EN
                sub = (mcnt / 4 > 75) ? 75 : mcnt / 4;
`endif
                mgap = 150 - sub + rnd / 4;
                mcnt = (mcnt < 255) ? mcnt + 1 : 255;
                mpul = 1;
            end else movf = 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, a, e);
        end
    endtask

    task automatic compare_model();
        logic [2:0]  ev;
        logic [32:0] ex;
        logic [5:0]  et;
        for (int i = 0; i < 3; i++) begin
            ev[i] = mv[i][0];
            ex[i*11 +: 11] = 11'(mx[i]);
            et[i*2 +: 2] = 2'(mt[i]);
        end
        chk("model_valid", 64'(slot_valid), 64'(ev));
        chk("model_x", 64'(slot_x), 64'(ex));
        chk("model_type", 64'(slot_type), 64'(et));
        chk("model_pulse", 64'(spawn_pulse), 64'(mpul));
        chk("model_running", 64'(running), 64'(mmode == 1));
        chk("model_overflow", 64'(overflow), 64'(movf));
    endtask

    task automatic step(input bit t, input bit h, input bit r, input logic [7:0] rnd);
        tick = t; halt = h; restart = r; random = rnd;
        @(posedge clk);
        model_step(t, h, r, int'(rnd));
        #1;
        compare_model();
    endtask

    typedef struct {
        int         rep;
        bit         t, h, r;
        logic [7:0] rnd;
        logic [2:0] ev;
        logic [5:0] et;
        logic [10:0] ex0;
        bit         erun, epul, eovf;
    } vec_t;
    vec_t tbl[14];

    initial begin
        tbl[0]  = '{10,  1, 0, 0, 8'd0, 3'd0, 6'd0, 11'd0,   0, 0, 0};
        tbl[1]  = '{1,   0, 0, 1, 8'd0, 3'd0, 6'd0, 11'd0,   1, 0, 0};
        tbl[2]  = '{64,  1, 0, 0, 8'd5, 3'd0, 6'd0, 11'd0,   1, 0, 0};
        tbl[3]  = '{1,   1, 0, 0, 8'd5, 3'd1, 6'd1, 11'd666, 1, 1, 0};
        tbl[4]  = '{1,   0, 0, 0, 8'd5, 3'd1, 6'd1, 11'd666, 1, 0, 0};
        tbl[5]  = '{150, 1, 0, 0, 8'd5, 3'd1, 6'd1, 11'd516, 1, 0, 0};
        tbl[6]  = '{1,   1, 0, 0, 8'd5, 3'd1, 6'd1, 11'd515, 1, 0, 0};
        tbl[7]  = '{1,   1, 0, 0, 8'd7, 3'd3, 6'd1, 11'd514, 1, 1, 0};
        tbl[8]  = '{1,   1, 1, 1, 8'd0, 3'd0, 6'd0, 11'd0,   1, 0, 0};
        tbl[9]  = '{65,  1, 0, 0, 8'd0, 3'd1, 6'd0, 11'd666, 1, 1, 0};
        tbl[10] = '{5,   1, 0, 0, 8'd0, 3'd1, 6'd0, 11'd661, 1, 0, 0};
        tbl[11] = '{1,   1, 1, 0, 8'd0, 3'd1, 6'd0, 11'd661, 0, 0, 0};
        tbl[12] = '{20,  1, 0, 0, 8'd0, 3'd1, 6'd0, 11'd661, 0, 0, 0};
        tbl[13] = '{1,   0, 0, 1, 8'd0, 3'd0, 6'd0, 11'd0,   1, 0, 0};

        model_clear(); mmode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(slot_valid), 0);
        chk("reset_x", 64'(slot_x), 0);
        chk("reset_running", 64'(running), 0);
        chk("reset_pulse", 64'(spawn_pulse), 0);
        reset_n = 1;

        for (int k = 0; k < 14; k++) begin
            for (int j = 0; j < tbl[k].rep; j++) step(tbl[k].t, tbl[k].h, tbl[k].r, tbl[k].rnd);
            chk($sformatf("vec%0d_valid", k), 64'(slot_valid), 64'(tbl[k].ev));
            chk($sformatf("vec%0d_type", k), 64'(slot_type), 64'(tbl[k].et));
            chk($sformatf("vec%0d_x0", k), 64'(slot_x[10:0]), 64'(tbl[k].ex0));
            chk($sformatf("vec%0d_running", k), 64'(running), 64'(tbl[k].erun));
            chk($sformatf("vec%0d_pulse", k), 64'(spawn_pulse), 64'(tbl[k].epul));
            chk($sformatf("vec%0d_overflow", k), 64'(overflow), 64'(tbl[k].eovf));
        end

        // scroll and retire: slot 0 lives exactly 666 ticks, later spawns overflow until it leaves
        repeat (65) step(1, 0, 0, 8'd5);
        for (int j = 1; j <= 666; j++) begin
            step(1, 0, 0, 8'd5);
            if (j == 333) chk("scroll_x0_mid", 64'(slot_x[10:0]), 64'(SPAWN - 333));
        end
        chk("retire_valid", 64'(slot_valid), 64'(3'b110));
        chk("retire_x0", 64'(slot_x[10:0]), 0);
        chk("retire_overflow", 64'(overflow), 1);
        step(1, 0, 0, 8'd5);
        chk("respawn_valid", 64'(slot_valid), 64'(3'b111));
        chk("respawn_x0", 64'(slot_x[10:0]), 64'(SPAWN));
        chk("respawn_pulse", 64'(spawn_pulse), 1);

        // overflow with the short-gap instance: spawns at ticks 65, 76, 87; 98 is due but full
        step(0, 0, 1, 8'd0);
        chk("ovf_clear", 64'(o2), 0);
        repeat (97) step(1, 0, 0, 8'd0);
        chk("ovf_full", 64'(v2), 64'(3'b111));
        chk("ovf_not_yet", 64'(o2), 0);
        step(1, 0, 0, 8'd0);
        chk("ovf_set", 64'(o2), 1);
        repeat (632) step(1, 0, 0, 8'd0);
        chk("ovf_still_full", 64'(v2), 64'(3'b111));
        step(1, 0, 0, 8'd0);
        chk("ovf_slot0_retired", 64'(v2), 64'(3'b110));
        chk("ovf_no_same_tick_spawn", 64'(p2), 0);
        step(1, 0, 0, 8'd0);
        chk("ovf_spawn_slot0", 64'(v2), 64'(3'b111));
        chk("ovf_spawn_x0", 64'(x2[10:0]), 64'(SPAWN));
        chk("ovf_spawn_pulse", 64'(p2), 1);
        chk("ovf_sticky", 64'(o2), 1);

        // asynchronous reset mid-run, away from any clock edge
        #3 reset_n = 0;
        #1;
        chk("async_valid", 64'(slot_valid), 0);
        chk("async_x", 64'(slot_x), 0);
        chk("async_running", 64'(running), 0);
        chk("async_overflow", 64'(overflow), 0);
        model_clear(); mmode = 0;
        @(posedge clk);
        #1 reset_n = 1;

        for (int j = 0; j < 3000; j++)
            step($urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0,
                 (j == 0) || ($urandom_range(299, 0) == 0), 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
